// File: rtl/camera_config.sv
// OV7670 bring-up sequencer: walks the register ROM and issues a write-only SCCB
// transaction for each {reg, value} entry, with a delay marker and an end marker.
module camera_config #(
    parameter int         CLK_FREQ     = 25_000_000,
    parameter int         SCCB_FREQ    = 100_000,
    parameter logic [7:0] DEV_ADDR     = 8'h42,
    parameter int         DELAY_CYCLES = 250_000
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_start,
    output logic [7:0]  o_addr,
    input  logic [15:0] i_dout,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_sioc,
    output logic        o_siod,
    output logic        o_siod_oe
);

    localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
    localparam int DW  = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_START,
        S_BITS, S_STOP, S_GAP, S_DELAY, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [QW-1:0]  qcnt_q;
    logic [1:0]     qtr_q;
    logic [4:0]     bit_idx_q;
    logic [DW-1:0]  dly_cnt_q;
    logic [15:0]    tx_data;
    logic [26:0]    tx_frame;

    logic bus_state, qtr_end, bit_end, dly_end, start_acc, entry_end, dc_bit;

    assign bus_state = (state_q == S_START) || (state_q == S_BITS) ||
                       (state_q == S_STOP)  || (state_q == S_GAP);
    assign qtr_end   = (qcnt_q == QW'(QTR - 1));
    assign bit_end   = qtr_end && (qtr_q == 2'd3);
    assign dly_end   = (dly_cnt_q == DW'(DELAY_CYCLES - 1));
    assign start_acc = i_start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign entry_end = ((state_q == S_GAP) && bit_end) || ((state_q == S_DELAY) && dly_end);

    // Each byte is followed by a released don't-care (ACK) slot; ACK is never sampled.
    assign tx_frame  = {DEV_ADDR, 1'b1, tx_data[15:8], 1'b1, tx_data[7:0], 1'b1};
    assign dc_bit    = (bit_idx_q == 5'd8) || (bit_idx_q == 5'd17) || (bit_idx_q == 5'd26);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (i_start) state_d = S_FETCH;
            S_FETCH:        state_d = S_WAIT;
            S_WAIT:         state_d = S_DECODE;
            S_DECODE: begin
                if (i_dout == 16'hFFFF)      state_d = S_DONE;
                else if (i_dout == 16'hFFF0) state_d = S_DELAY;
                else                         state_d = S_START;
            end
            S_START:        if (bit_end) state_d = S_BITS;
            S_BITS:         if (bit_end && (bit_idx_q == 5'd26)) state_d = S_STOP;
            S_STOP:         if (bit_end) state_d = S_GAP;
            S_GAP, S_DELAY: if (entry_end) state_d = (o_addr == 8'hFF) ? S_DONE : S_FETCH;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy    = 1'b1;
        o_done    = 1'b0;
        o_sioc    = 1'b1;
        o_siod    = 1'b1;
        o_siod_oe = 1'b0;
        case (state_q)
            S_IDLE: o_busy = 1'b0;
            S_DONE: begin
                o_busy = 1'b0;
                o_done = 1'b1;
            end
            S_START: begin
                o_siod_oe = 1'b1;
                o_siod    = (qtr_q == 2'd0);
                o_sioc    = !qtr_q[1];
            end
            S_BITS: begin
                o_siod_oe = !dc_bit;
                o_siod    = dc_bit ? 1'b1 : tx_frame[5'd26 - bit_idx_q];
                o_sioc    = qtr_q[1];
            end
            S_STOP: begin
                o_sioc    = (qtr_q != 2'd0);
                o_siod_oe = !qtr_q[1];
                o_siod    = qtr_q[1];
            end
            default: ;
        endcase
    end

    // Quarter/bit timing restarts from zero on entry to every bus phase.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            qcnt_q    <= '0;
            qtr_q     <= 2'd0;
            bit_idx_q <= 5'd0;
            dly_cnt_q <= '0;
        end else begin
            if (bus_state) begin
                if (qtr_end) begin
                    qcnt_q <= '0;
                    qtr_q  <= qtr_q + 2'd1;
                end else begin
                    qcnt_q <= qcnt_q + QW'(1);
                end
            end else begin
                qcnt_q <= '0;
                qtr_q  <= 2'd0;
            end

            if (state_q != S_BITS)  bit_idx_q <= 5'd0;
            else if (bit_end)       bit_idx_q <= bit_idx_q + 5'd1;

            if (state_q != S_DELAY) dly_cnt_q <= '0;
            else                    dly_cnt_q <= dly_cnt_q + DW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_addr <= 8'd0;
        end else if (start_acc) begin
            o_addr <= 8'd0;
        end else if (entry_end && (o_addr != 8'hFF)) begin
            o_addr <= o_addr + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (state_q == S_DECODE) tx_data <= i_dout;
    end

endmodule

// File: tb/tb_camera_config.sv
// Directed bench for camera_config: a registered ROM model feeds the DUT and a
// bus monitor decodes SCCB frames from the SIOC/SIOD pin levels.
module tb_camera_config;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic        i_start;
    logic [7:0]  o_addr;
    logic [15:0] i_dout;
    logic        o_busy, o_done, o_sioc, o_siod, o_siod_oe;

    camera_config #(
        .CLK_FREQ(800), .SCCB_FREQ(100), .DEV_ADDR(8'h42), .DELAY_CYCLES(50)
    ) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .o_addr(o_addr),
        .i_dout(i_dout), .o_busy(o_busy), .o_done(o_done), .o_sioc(o_sioc),
        .o_siod(o_siod), .o_siod_oe(o_siod_oe)
    );

    always #5 i_clk = ~i_clk;

    logic [15:0] rom [256];
    always @(posedge i_clk) i_dout <= rom[o_addr];

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus monitor: frame = start condition .. stop condition on the pin level.
    typedef struct { logic [27:0] sh; int rises; } frame_t;
    frame_t frames[$];
    int     toggles = 0;
    int     viol    = 0;

    initial begin
        logic        p_sioc, p_line, line, in_frame, pv;
        logic [27:0] sh;
        int          rises;
        frame_t      fr;
        pv = 1'b0; in_frame = 1'b0; sh = '0; rises = 0; p_sioc = 1'b1; p_line = 1'b1;
        forever begin
            @(negedge i_clk);
            line = o_siod_oe ? o_siod : 1'b1;
            if (!i_rstn) begin
                in_frame = 1'b0;
                pv       = 1'b0;
            end else begin
                if (pv) begin
                    if (o_sioc != p_sioc) toggles++;
                    if (line != p_line) begin
                        if (p_sioc && o_sioc) begin
                            if (!line) begin
                                if (in_frame) viol++;
                                in_frame = 1'b1; sh = '0; rises = 0;
                            end else if (!in_frame) begin
                                viol++;
                            end else begin
                                fr.sh = sh; fr.rises = rises;
                                frames.push_back(fr);
                                in_frame = 1'b0;
                            end
                        end else if (o_sioc) begin
                            viol++;
                        end
                    end
                    if (!p_sioc && o_sioc && in_frame) begin
                        sh = {sh[26:0], line};
                        rises++;
                    end
                end
                p_sioc = o_sioc; p_line = line; pv = 1'b1;
            end
        end
    end

    task automatic do_start();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1 i_start = 1'b0;
    endtask

    // Returns the number of clock edges after the start edge at which o_done was seen.
    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        forever begin
            @(negedge i_clk);
            if (o_done || cyc >= bound) break;
            @(posedge i_clk);
            cyc++;
        end
    endtask

    task automatic load_rom(input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
        for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
        rom[0] = e0; rom[1] = e1; rom[2] = e2;
    endtask

    typedef struct {
        logic [15:0] e0, e1, e2;
        int          cyc;
        int          nfr;
        logic [7:0]  r_first, v_first, r_last, v_last;
        logic [7:0]  end_addr;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc, fr0, tg0, vi0;

        // write entry = 3 + 240 cycles, delay entry = 3 + 50, end marker = 3
        vecs[0] = '{16'h1204, 16'hFFFF, 16'hFFFF, 246, 1, 8'h12, 8'h04, 8'h12, 8'h04, 8'd1};
        vecs[1] = '{16'hFFF0, 16'hFFFF, 16'hFFFF,  56, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd1};
        vecs[2] = '{16'hFFFF, 16'h1204, 16'hFFFF,   3, 0, 8'h00, 8'h00, 8'h00, 8'h00, 8'd0};
        vecs[3] = '{16'hA53C, 16'hFFF0, 16'hFFFF, 299, 1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'd2};
        vecs[4] = '{16'h0080, 16'h7F01, 16'hFFFF, 489, 2, 8'h00, 8'h80, 8'h7F, 8'h01, 8'd2};

        i_rstn  = 1'b0;
        i_start = 1'b0;
        load_rom(16'hFFFF, 16'hFFFF, 16'hFFFF);
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_sioc", o_sioc, 1);
        check("rst_siod", o_siod, 1);
        check("rst_oe",   o_siod_oe, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        check("rst_addr", o_addr, 0);
        i_rstn = 1'b1;

        foreach (vecs[k]) begin
            load_rom(vecs[k].e0, vecs[k].e1, vecs[k].e2);
            fr0 = frames.size(); tg0 = toggles; vi0 = viol;
            do_start();
            wait_done(2000, cyc);
            check($sformatf("v%0d_cycles", k), cyc, vecs[k].cyc);
            check($sformatf("v%0d_busy", k), o_busy, 0);
            check($sformatf("v%0d_addr", k), o_addr, vecs[k].end_addr);
            check($sformatf("v%0d_frames", k), frames.size() - fr0, vecs[k].nfr);
            // 56 SIOC transitions per write: START fall, 27 rises, 26+1 falls, STOP rise
            check($sformatf("v%0d_toggles", k), toggles - tg0, 56 * vecs[k].nfr);
            check($sformatf("v%0d_viol", k), viol - vi0, 0);
            if (frames.size() - fr0 == vecs[k].nfr && vecs[k].nfr > 0) begin
                // 28 rising edges: 27 bit clocks plus the STOP clock-high before SIOD rises
                check($sformatf("v%0d_rises", k), frames[fr0].rises, 28);
                check($sformatf("v%0d_dev", k), frames[fr0].sh[27:20], 8'h42);
                check($sformatf("v%0d_reg", k), frames[fr0].sh[18:11], vecs[k].r_first);
                check($sformatf("v%0d_val", k), frames[fr0].sh[9:2], vecs[k].v_first);
                check($sformatf("v%0d_stopbit", k), frames[fr0].sh[0], 0);
                check($sformatf("v%0d_lreg", k), frames[frames.size()-1].sh[18:11], vecs[k].r_last);
                check($sformatf("v%0d_lval", k), frames[frames.size()-1].sh[9:2], vecs[k].v_last);
            end
        end

        // Asynchronous reset in the middle of the second entry's BITS phase.
        load_rom(16'h1204, 16'h3456, 16'hFFFF);
        do_start();
        repeat (243 + 40) @(posedge i_clk);
        check("mid_addr", o_addr, 1);
        #2 i_rstn = 1'b0;
        @(negedge i_clk);
        check("mrst_sioc", o_sioc, 1);
        check("mrst_oe",   o_siod_oe, 0);
        check("mrst_busy", o_busy, 0);
        check("mrst_addr", o_addr, 0);
        i_rstn = 1'b1;

        // Start during BITS is ignored; start in DONE reruns from address 0.
        load_rom(16'h1204, 16'h7F01, 16'hFFFF);
        do_start();
        repeat (243 + 40) @(posedge i_clk);
        do_start();
        @(negedge i_clk);
        check("ign_addr", o_addr, 1);
        check("ign_busy", o_busy, 1);
        check("ign_done", o_done, 0);
        wait_done(2000, cyc);
        check("ign_fin_done", o_done, 1);
        check("ign_fin_addr", o_addr, 2);
        fr0 = frames.size();
        do_start();
        @(negedge i_clk);
        check("rerun_done", o_done, 0);
        check("rerun_busy", o_busy, 1);
        check("rerun_addr", o_addr, 0);
        wait_done(2000, cyc);
        // one negedge already consumed above, so 489 - 1
        check("rerun_cycles", cyc, 488);
        check("rerun_frames", frames.size() - fr0, 2);

        // No end marker anywhere: 256 writes, address parks at 255.
        for (int i = 0; i < 256; i++) rom[i] = {i[7:0], ~i[7:0]};
        fr0 = frames.size(); vi0 = viol;
        do_start();
        wait_done(70000, cyc);
        check("nowrap_cycles", cyc, 256 * 243);
        check("nowrap_done", o_done, 1);
        check("nowrap_addr", o_addr, 255);
        check("nowrap_frames", frames.size() - fr0, 256);
        check("nowrap_viol", viol - vi0, 0);
        if (frames.size() - fr0 == 256) begin
            check("nowrap_lreg", frames[frames.size()-1].sh[18:11], 8'hFF);
            check("nowrap_lval", frames[frames.size()-1].sh[9:2], 8'h00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
